// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: buffered echo engine between UART RX strobe and TX handshake.
// FIFO queue, transmit FSM, case-swap transform and saturating status counters.
module uart_echo_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_error,
    input  logic                       tx_busy,
    input  logic [1:0]                 mode,
    input  logic                       flush,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    output logic [DATA_W-1:0]          rx_last,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           overflow_cnt,
    output logic [CNT_W-1:0]           err_cnt,
    output logic                       debug_toggle
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              accept;
    logic              push;
    logic              pop;
    logic              drop_full;
    logic              err_hit;

    // Mode 01 swaps ASCII letter case by flipping bit 5; other bytes pass.
    function automatic logic [DATA_W-1:0] xform(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        m
    );
        logic [DATA_W-1:0] r;
        logic              upper;
        logic              lower;
        r     = d;
        upper = (d >= DATA_W'('h41)) && (d <= DATA_W'('h5A));
        lower = (d >= DATA_W'('h61)) && (d <= DATA_W'('h7A));
        if (DATA_W == 8 && m == 2'b01 && (upper || lower))
            r = d ^ DATA_W'('h20);
        return r;
    endfunction

    // Full/empty come from the level counter; a pop frees a slot in the same cycle.
    assign full      = (fifo_level == LW'(DEPTH));
    assign pop       = (state == IDLE) && (fifo_level != '0) &&
                       (mode != 2'b10) && !tx_busy && !flush;
    assign accept    = rx_valid && !rx_error && (mode != 2'b11) && !flush;
    assign push      = accept && (!full || pop);
    assign drop_full = accept && full && !pop;
    assign err_hit   = rx_valid && rx_error;

    // Storage array, written on every successful push.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rx_data;
    end

    // Pointers and level; flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

    // Status: last stored byte, activity toggle and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_last      <= '0;
            debug_toggle <= 1'b0;
            overflow_cnt <= '0;
            err_cnt      <= '0;
        end else begin
            if (push) begin
                rx_last      <= rx_data;
                debug_toggle <= ~debug_toggle;
            end
            if (drop_full && overflow_cnt != '1)
                overflow_cnt <= overflow_cnt + CNT_W'(1);
            if (err_hit && err_cnt != '1)
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    // Transmit FSM: pop and strobe once, then follow the core's busy cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= xform(mem[rd_ptr], mode);
                        tx_start <= 1'b1;
                        state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: directed stimulus, queue scoreboard, TX monitor.
// A small UART core model answers each tx_start with a busy window.
module tb_uart_echo_fifo;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_error = 1'b0;
    logic          tx_busy = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          flush = 1'b0;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] rx_last;
    logic [$clog2(DP):0] fifo_level;
    logic [CW-1:0] overflow_cnt;
    logic [CW-1:0] err_cnt;
    logic          debug_toggle;

    int total = 0;
    int bad = 0;
    int core_len = 3;
    logic [DW-1:0] sb [$];

    uart_echo_fifo #(
        .DATA_W (DW),
        .DEPTH  (DP),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_error     (rx_error),
        .tx_busy      (tx_busy),
        .mode         (mode),
        .flush        (flush),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .rx_last      (rx_last),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt),
        .err_cnt      (err_cnt),
        .debug_toggle (debug_toggle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // UART core model: busy rises after a strobe, lasts core_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx_start) begin
                tx_busy = 1'b1;
                repeat (core_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    // Monitor: every strobe pops one expected byte.
    initial begin
        logic prev;
        logic [DW-1:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && tx_start) begin
                total++;
                if (prev) begin
                    bad++;
                    $display("FAIL tx_width act=2 exp=1");
                end else if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL tx_extra act=%0h exp=none", tx_data);
                end else begin
                    e = sb.pop_front();
                    if (tx_data !== e) begin
                        bad++;
                        $display("FAIL tx_data act=%0h exp=%0h",
                                 tx_data, e);
                    end
                end
            end
            prev = tx_start && !rst;
        end
    end

    task automatic send(input logic [DW-1:0] d);
        @(negedge clk);
        rx_data  = d;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int st;
        st = 0;
        for (int i = 0; i < 2000 && st < 4; i++) begin
            @(negedge clk);
            if (fifo_level == 0 && !tx_busy && !tx_start)
                st++;
            else
                st = 0;
        end
        if (st < 4) begin
            total++;
            bad++;
            $display("FAIL %s_timeout act=busy exp=idle", nm);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_start", tx_start, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_data", tx_data, 0);
        rst = 1'b0;

        // 1: plain echo, latency and pulse width
        mode = 2'b00;
        sb.push_back(8'h41);
        send(8'h41);
        chk("t1_early", tx_start, 0);
        @(negedge clk);
        chk("t1_start", tx_start, 1);
        chk("t1_data", tx_data, 8'h41);
        @(negedge clk);
        chk("t1_width", tx_start, 0);
        chk("t1_last", rx_last, 8'h41);
        chk("t1_tog", debug_toggle, 1);
        wait_idle("t1");

        // 2: case-swap transform, order kept
        mode = 2'b01;
        sb.push_back(8'h41);
        sb.push_back(8'h7A);
        sb.push_back(8'h31);
        send(8'h61);
        send(8'h5A);
        send(8'h31);
        wait_idle("t2");
        chk("t2_tog", debug_toggle, 0);

        // 3: hold mode fills to DEPTH, extras dropped
        mode = 2'b10;
        for (int i = 1; i <= 6; i++)
            send(8'(i));
        @(negedge clk);
        chk("t3_level", fifo_level, 4);
        chk("t3_ovf", overflow_cnt, 2);
        chk("t3_hold", tx_start, 0);
        for (int i = 1; i <= 4; i++)
            sb.push_back(8'(i));
        mode = 2'b00;
        wait_idle("t3");
        chk("t3_empty", fifo_level, 0);
        chk("t3_last", rx_last, 8'h04);

        // discard mode stores nothing
        mode = 2'b11;
        send(8'h77);
        @(negedge clk);
        chk("d_level", fifo_level, 0);
        chk("d_last", rx_last, 8'h04);
        mode = 2'b00;

        // 4: framing errors, counter saturation
        rx_error = 1'b1;
        send(8'hFF);
        chk("t4_err", err_cnt, 1);
        chk("t4_level", fifo_level, 0);
        chk("t4_last", rx_last, 8'h04);
        @(negedge clk);
        rx_valid = 1'b1;
        repeat (299) @(negedge clk);
        rx_valid = 1'b0;
        rx_error = 1'b0;
        @(negedge clk);
        chk("t4_sat", err_cnt, 255);

        // 5: flush with same-cycle byte, in-flight byte completes
        core_len = 20;
        sb.push_back(8'h10);
        send(8'h10);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            rx_data  = 8'(16 + i);
            rx_valid = 1'b1;
        end
        @(negedge clk);
        chk("t5_level3", fifo_level, 3);
        rx_data  = 8'h14;
        flush    = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        flush    = 1'b0;
        chk("t5_flush", fifo_level, 0);
        chk("t5_ovf", overflow_cnt, 2);
        chk("t5_last", rx_last, 8'h13);
        wait_idle("t5");

        // 6: reset mid-transmission, then normal echo
        core_len = 6;
        sb.push_back(8'h20);
        send(8'h20);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_start", tx_start, 0);
        chk("t6_data", tx_data, 0);
        chk("t6_last", rx_last, 0);
        chk("t6_ovf", overflow_cnt, 0);
        chk("t6_err", err_cnt, 0);
        chk("t6_tog", debug_toggle, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_idle("t6a");
        sb.push_back(8'h55);
        send(8'h55);
        wait_idle("t6b");
        chk("t6_echo", tx_data, 8'h55);
        chk("t6_last55", rx_last, 8'h55);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
